// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and frame lengths.
// Used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam logic START_BIT         = 1'b0;
   localparam logic STOP_BIT          = 1'b1;
   localparam int   DATA_BITS         = 8;
   localparam int   FRAME_BITS_BASE   = 10;
   localparam int   FRAME_BITS_PARITY = 11;

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator: one tick every CLK_FREQ/BAUD clocks while en is high.
// The count is held at zero while en is low, so each enable starts a fresh period.
module uart_baud_gen #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int DIV = (CLK_FREQ / BAUD < 1) ? 1 : CLK_FREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!en || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: DEPTH-byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to append an even-parity bit after data bit 7.
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 1_000_000,
   parameter int DEPTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   output logic                     busy,
   output logic                     tx
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          fifo_ne;
   logic          tick;
   logic          line_bit;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   uart_state_t   state;
`ifdef UART_TX_PARITY_EN
   logic          par;
`endif

   // Full comes from the registered count, so a same-cycle pop never frees a slot.
   assign fifo_ne = (count != '0);
   assign full    = (count == (AW + 1)'(DEPTH));
   assign push    = wr_en && !full;
   assign pop     = fifo_ne && ((state == IDLE) || (state == STOP && tick));
   assign level   = count;

   uart_baud_gen #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (state != IDLE),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         ovf <= wr_en && full;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
         par   <= even_parity(mem[rd_ptr]);
`endif
      end else if (state == DATA && tick) begin
         shift <= shift >> 1;
      end
   end

   always_comb begin
      line_bit = STOP_BIT;
      case (state)
         START:   line_bit = START_BIT;
         DATA:    line_bit = shift[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  line_bit = par;
`endif
         default: line_bit = STOP_BIT;
      endcase
   end

   // tx and busy follow the state by one register stage, giving the two-cycle write-to-line latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         tx      <= STOP_BIT;
         busy    <= 1'b0;
      end else begin
         tx   <= line_bit;
         busy <= (state != IDLE) || fifo_ne;
         case (state)
            IDLE: begin
               if (fifo_ne) begin
                  state <= START;
               end
            end
            START: begin
               if (tick) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (tick) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  state <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  state <= fifo_ne ? START : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
